// File: rtl/flex_fifo.sv
// flex_fifo: single-clock FIFO using the full 2**ADDR_WIDTH capacity, with an
// occupancy count, registered status flags, sticky overflow/underflow flags and
// a selectable read mode (fall-through or registered read with a valid strobe).
//
// Handshake: push and pop are requests, not valid/ready pairs. A pop is
// accepted when the FIFO is not empty. A push is accepted when the FIFO is not
// full, or when it is full but a pop is accepted in the same cycle. A rejected
// request changes no state except the matching sticky error flag. rd_valid
// qualifies rd_data. With FWFT=1 it is high whenever a word is presented. With
// FWFT=0 it is high for exactly the one cycle after each accepted pop.
module flex_fifo #(
    parameter int ADDR_WIDTH             = 4,
    parameter int DATA_WIDTH             = 8,
    parameter bit FWFT                   = 1'b1,
    parameter int ALMOST_FULL_THRESHOLD  = (2 ** ADDR_WIDTH) - 4,
    parameter int ALMOST_EMPTY_THRESHOLD = 1
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic                  clear,
    input  logic                  push,
    input  logic [DATA_WIDTH-1:0] wr_data,
    input  logic                  pop,
    output logic [DATA_WIDTH-1:0] rd_data,
    output logic                  rd_valid,
    output logic                  empty,
    output logic                  full,
    output logic                  almost_empty,
    output logic                  almost_full,
    output logic [ADDR_WIDTH:0]   count,
    output logic                  overflow,
    output logic                  underflow
);

    localparam int DEPTH = 2 ** ADDR_WIDTH;
    localparam logic [ADDR_WIDTH:0] DEPTH_C = (ADDR_WIDTH + 1)'(DEPTH);
    localparam logic [ADDR_WIDTH:0] AF_C    = (ADDR_WIDTH + 1)'(ALMOST_FULL_THRESHOLD);
    localparam logic [ADDR_WIDTH:0] AE_C    = (ADDR_WIDTH + 1)'(ALMOST_EMPTY_THRESHOLD);

    logic [DATA_WIDTH-1:0] mem [DEPTH];

    logic [ADDR_WIDTH-1:0] wr_ptr_q, wr_ptr_d;
    logic [ADDR_WIDTH-1:0] rd_ptr_q, rd_ptr_d;
    logic [ADDR_WIDTH:0]   count_q, count_d;
    logic                  empty_q, empty_d;
    logic                  full_q, full_d;
    logic                  almost_empty_q, almost_empty_d;
    logic                  almost_full_q, almost_full_d;
    logic                  overflow_q, overflow_d;
    logic                  underflow_q, underflow_d;
    logic                  rd_valid_q, rd_valid_d;
    logic [DATA_WIDTH-1:0] rd_data_q, rd_data_d;

    logic                  flush;
    logic                  pop_acc;
    logic                  push_acc;

    // Acceptance and next-state; flags derive from the next count so they match count every cycle.
    always_comb begin
        flush    = rst || clear;
        pop_acc  = pop && !empty_q;
        push_acc = push && (!full_q || pop_acc);

        wr_ptr_d       = wr_ptr_q + ADDR_WIDTH'(push_acc);
        rd_ptr_d       = rd_ptr_q + ADDR_WIDTH'(pop_acc);
        count_d        = count_q + (ADDR_WIDTH + 1)'(push_acc) - (ADDR_WIDTH + 1)'(pop_acc);
        empty_d        = (count_d == '0);
        full_d         = (count_d == DEPTH_C);
        almost_empty_d = (count_d <= AE_C);
        almost_full_d  = (count_d >= AF_C);
        overflow_d     = overflow_q || (push && !push_acc);
        underflow_d    = underflow_q || (pop && !pop_acc);
        rd_valid_d     = pop_acc;
        rd_data_d      = pop_acc ? mem[rd_ptr_q] : rd_data_q;
    end

    // Control and status registers; rst and clear both flush and override any request.
    always_ff @(posedge clk) begin
        if (rst || clear) begin
            wr_ptr_q       <= '0;
            rd_ptr_q       <= '0;
            count_q        <= '0;
            empty_q        <= 1'b1;
            full_q         <= 1'b0;
            almost_empty_q <= 1'b1;
            almost_full_q  <= 1'b0;
            overflow_q     <= 1'b0;
            underflow_q    <= 1'b0;
            rd_valid_q     <= 1'b0;
            rd_data_q      <= '0;
        end else begin
            wr_ptr_q       <= wr_ptr_d;
            rd_ptr_q       <= rd_ptr_d;
            count_q        <= count_d;
            empty_q        <= empty_d;
            full_q         <= full_d;
            almost_empty_q <= almost_empty_d;
            almost_full_q  <= almost_full_d;
            overflow_q     <= overflow_d;
            underflow_q    <= underflow_d;
            rd_valid_q     <= rd_valid_d;
            rd_data_q      <= rd_data_d;
        end
    end

    // Storage array; not reset, and a push coinciding with a flush is dropped.
    always_ff @(posedge clk) begin
        if (push_acc && !flush) begin
            mem[wr_ptr_q] <= wr_data;
        end
    end

    // Output mapping; fall-through mode presents the head entry directly.
    always_comb begin
        rd_data      = FWFT ? mem[rd_ptr_q] : rd_data_q;
        rd_valid     = FWFT ? !empty_q : rd_valid_q;
        empty        = empty_q;
        full         = full_q;
        almost_empty = almost_empty_q;
        almost_full  = almost_full_q;
        count        = count_q;
        overflow     = overflow_q;
        underflow    = underflow_q;
    end

endmodule

// File: tb/tb_flex_fifo.sv
// tb_flex_fifo: directed vectors applied to a fall-through and a registered-read
// instance sharing the same stimulus (DEPTH 4, thresholds 3/1).
module tb_flex_fifo;

    logic       clk = 1'b0;
    logic       rst = 1'b0;
    logic       clear = 1'b0;
    logic       push = 1'b0;
    logic       pop = 1'b0;
    logic [7:0] wr_data = '0;

    logic [7:0] f_rd_data, r_rd_data;
    logic       f_rd_valid, r_rd_valid;
    logic       f_empty, f_full, f_ae, f_af, f_ovf, f_unf;
    logic       r_empty, r_full, r_ae, r_af, r_ovf, r_unf;
    logic [2:0] f_count, r_count;

    int checks = 0;
    int failures = 0;

    // clock
    always #5 clk = ~clk;

    flex_fifo #(
        .ADDR_WIDTH(2), .DATA_WIDTH(8), .FWFT(1'b1),
        .ALMOST_FULL_THRESHOLD(3), .ALMOST_EMPTY_THRESHOLD(1)
    ) u_fwft (
        .clk(clk), .rst(rst), .clear(clear), .push(push), .wr_data(wr_data), .pop(pop),
        .rd_data(f_rd_data), .rd_valid(f_rd_valid), .empty(f_empty), .full(f_full),
        .almost_empty(f_ae), .almost_full(f_af), .count(f_count),
        .overflow(f_ovf), .underflow(f_unf)
    );

    flex_fifo #(
        .ADDR_WIDTH(2), .DATA_WIDTH(8), .FWFT(1'b0),
        .ALMOST_FULL_THRESHOLD(3), .ALMOST_EMPTY_THRESHOLD(1)
    ) u_reg (
        .clk(clk), .rst(rst), .clear(clear), .push(push), .wr_data(wr_data), .pop(pop),
        .rd_data(r_rd_data), .rd_valid(r_rd_valid), .empty(r_empty), .full(r_full),
        .almost_empty(r_ae), .almost_full(r_af), .count(r_count),
        .overflow(r_ovf), .underflow(r_unf)
    );

    typedef struct {
        logic       rst;
        logic       clr;
        logic       push;
        logic       pop;
        logic [7:0] wd;
        int         cnt;   // expected count after the edge
        logic       ovf;
        logic       unf;
        logic       chk;   // fall-through rd_data is defined (FIFO non-empty)
        logic [7:0] rd;    // expected fall-through rd_data after the edge
    } vec_t;

    vec_t vecs[$];

    function automatic vec_t mk(logic r, logic c, logic pu, logic po, logic [7:0] wd,
                                int cnt, logic ovf, logic unf, logic chk, logic [7:0] rd);
        vec_t v;
        v.rst = r; v.clr = c; v.push = pu; v.pop = po; v.wd = wd;
        v.cnt = cnt; v.ovf = ovf; v.unf = unf; v.chk = chk; v.rd = rd;
        return v;
    endfunction

    task automatic check(string name, logic [31:0] act, logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s actual=0x%0h expected=0x%0h", name, act, exp);
        end
    endtask

    // Drive one cycle of inputs at the falling edge, then sample just after the rising edge.
    task automatic step(logic r, logic c, logic pu, logic po, logic [7:0] wd);
        @(negedge clk);
        rst = r; clear = c; push = pu; pop = po; wr_data = wd;
        @(posedge clk);
        #1;
    endtask

    function automatic logic [5:0] flags_of(int cnt, logic ovf, logic unf);
        return {cnt == 0, cnt == 4, cnt <= 1, cnt >= 3, ovf, unf};
    endfunction

    initial begin
        vec_t v;
        int   prev_cnt = 0;
        logic [7:0] prev_rd = '0;
        logic exp_rv;
        logic [7:0] exp_rdq = '0;

        // reset
        vecs.push_back(mk(1,0,0,0,8'h00, 0,0,0,0,8'h00));
        // fill to full: almost_full at 3, full at 4
        vecs.push_back(mk(0,0,1,0,8'h11, 1,0,0,1,8'h11));
        vecs.push_back(mk(0,0,1,0,8'h22, 2,0,0,1,8'h11));
        vecs.push_back(mk(0,0,1,0,8'h33, 3,0,0,1,8'h11));
        vecs.push_back(mk(0,0,1,0,8'h44, 4,0,0,1,8'h11));
        // overflow, then drain in order (0x55 never stored)
        vecs.push_back(mk(0,0,1,0,8'h55, 4,1,0,1,8'h11));
        vecs.push_back(mk(0,0,0,1,8'h00, 3,1,0,1,8'h22));
        vecs.push_back(mk(0,0,0,1,8'h00, 2,1,0,1,8'h33));
        vecs.push_back(mk(0,0,0,1,8'h00, 1,1,0,1,8'h44));
        vecs.push_back(mk(0,0,0,1,8'h00, 0,1,0,0,8'h00));
        vecs.push_back(mk(0,1,0,0,8'h00, 0,0,0,0,8'h00));
        // push+pop at full
        vecs.push_back(mk(0,0,1,0,8'h11, 1,0,0,1,8'h11));
        vecs.push_back(mk(0,0,1,0,8'h22, 2,0,0,1,8'h11));
        vecs.push_back(mk(0,0,1,0,8'h33, 3,0,0,1,8'h11));
        vecs.push_back(mk(0,0,1,0,8'h44, 4,0,0,1,8'h11));
        vecs.push_back(mk(0,0,1,1,8'h66, 4,0,0,1,8'h22));
        vecs.push_back(mk(0,0,0,1,8'h00, 3,0,0,1,8'h33));
        vecs.push_back(mk(0,0,0,1,8'h00, 2,0,0,1,8'h44));
        vecs.push_back(mk(0,0,0,1,8'h00, 1,0,0,1,8'h66));
        vecs.push_back(mk(0,0,0,1,8'h00, 0,0,0,0,8'h00));
        // push+pop at empty: only the push is accepted
        vecs.push_back(mk(0,0,1,1,8'h77, 1,0,1,1,8'h77));
        vecs.push_back(mk(0,0,0,1,8'h00, 0,0,1,0,8'h00));
        vecs.push_back(mk(0,1,0,0,8'h00, 0,0,0,0,8'h00));
        // wrap-around at occupancy 2
        vecs.push_back(mk(0,0,1,0,8'hE0, 1,0,0,1,8'hE0));
        vecs.push_back(mk(0,0,1,0,8'hE1, 2,0,0,1,8'hE0));
        vecs.push_back(mk(0,0,1,1,8'h00, 2,0,0,1,8'hE1));
        for (int k = 1; k < 10; k++) begin
            vecs.push_back(mk(0,0,1,1,8'(k), 2,0,0,1,8'(k - 1)));
        end
        vecs.push_back(mk(0,0,0,1,8'h00, 1,0,0,1,8'h09));
        vecs.push_back(mk(0,0,0,1,8'h00, 0,0,0,0,8'h00));
        // reset mid-operation with a concurrent push
        vecs.push_back(mk(0,0,1,0,8'h01, 1,0,0,1,8'h01));
        vecs.push_back(mk(0,0,1,0,8'h02, 2,0,0,1,8'h01));
        vecs.push_back(mk(0,0,1,0,8'h03, 3,0,0,1,8'h01));
        vecs.push_back(mk(1,0,1,0,8'hBB, 0,0,0,0,8'h00));
        vecs.push_back(mk(0,0,1,0,8'hCC, 1,0,0,1,8'hCC));
        vecs.push_back(mk(0,0,0,1,8'h00, 0,0,0,0,8'h00));

        for (int i = 0; i < vecs.size(); i++) begin
            v = vecs[i];
            step(v.rst, v.clr, v.push, v.pop, v.wd);

            // registered-read expectation: the word popped is the one presented before the edge
            if (v.rst || v.clr) begin
                exp_rv  = 1'b0;
                exp_rdq = '0;
            end else if (v.pop && prev_cnt != 0) begin
                exp_rv  = 1'b1;
                exp_rdq = prev_rd;
            end else begin
                exp_rv  = 1'b0;
            end

            check($sformatf("v%0d_f_count", i), 32'(f_count), 32'(v.cnt));
            check($sformatf("v%0d_r_count", i), 32'(r_count), 32'(v.cnt));
            check($sformatf("v%0d_f_flags", i), 32'({f_empty, f_full, f_ae, f_af, f_ovf, f_unf}),
                  32'(flags_of(v.cnt, v.ovf, v.unf)));
            check($sformatf("v%0d_r_flags", i), 32'({r_empty, r_full, r_ae, r_af, r_ovf, r_unf}),
                  32'(flags_of(v.cnt, v.ovf, v.unf)));
            check($sformatf("v%0d_f_rd_valid", i), 32'(f_rd_valid), 32'(v.cnt != 0));
            if (v.chk) check($sformatf("v%0d_f_rd_data", i), 32'(f_rd_data), 32'(v.rd));
            check($sformatf("v%0d_r_rd_valid", i), 32'(r_rd_valid), 32'(exp_rv));
            check($sformatf("v%0d_r_rd_data", i), 32'(r_rd_data), 32'(exp_rdq));

            prev_cnt = v.cnt;
            prev_rd  = v.rd;
        end

        // registered-read latency and hold
        step(0, 0, 1, 0, 8'hA1);
        check("lat_push1_valid", 32'(r_rd_valid), 32'(0));
        check("lat_fwft_head", 32'(f_rd_data), 32'(8'hA1));
        step(0, 0, 1, 0, 8'hA2);
        check("lat_push2_valid", 32'(r_rd_valid), 32'(0));
        step(0, 0, 0, 1, 8'h00);
        check("lat_pop1_valid", 32'(r_rd_valid), 32'(1));
        check("lat_pop1_data", 32'(r_rd_data), 32'(8'hA1));
        step(0, 0, 0, 1, 8'h00);
        check("lat_pop2_valid", 32'(r_rd_valid), 32'(1));
        check("lat_pop2_data", 32'(r_rd_data), 32'(8'hA2));
        step(0, 0, 0, 0, 8'h00);
        check("lat_idle1_valid", 32'(r_rd_valid), 32'(0));
        check("lat_idle1_hold", 32'(r_rd_data), 32'(8'hA2));
        step(0, 0, 0, 0, 8'h00);
        check("lat_idle2_valid", 32'(r_rd_valid), 32'(0));
        check("lat_idle2_hold", 32'(r_rd_data), 32'(8'hA2));
        check("lat_end_count", 32'(r_count), 32'(0));
        check("lat_end_empty", 32'(r_empty), 32'(1));

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
